// File: rtl/mainfsm_pkg.sv
// Shared definitions for the multicycle main controller and the ALU decoder:
// state codes, opcode constants, aluop codes and the packed control word.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mainfsm_ctl.sv
// Moore control-word decode for the main controller; only the memory-wait
// states look at mem_ready.
module mainfsm_ctl
  import mainfsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.alusrcb = 2'b01;
        ctl.irwrite = mem_ready;
        ctl.pcwrite = mem_ready;
      end
      S_DECODE: ctl.alusrcb = 2'b11;
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
      end
      S_MEMRD: ctl.iord = 1'b1;
      S_MEMWB: begin
        ctl.memtoreg = 1'b1;
        ctl.regwrite = 1'b1;
      end
      // memwrite stays up for the whole stall so the memory sees a stable request
      S_MEMWR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_SUB;
        ctl.pcsrc   = 2'b01;
        ctl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        ctl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: ctl.regwrite = 1'b1;
      S_JEX: begin
        ctl.pcsrc   = 2'b10;
        ctl.pcwrite = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle MIPS-style main controller: state register, next-state logic
// and retired-instruction counter; control decode lives in mainfsm_ctl.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic        branch,
  output logic        pcwrite,
  output logic        illegal,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [1:0]  aluop,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  state_t      state_reg;
  state_t      state_next;
  logic        retire;
  logic [31:0] instret_reg;
  ctl_t        ctl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Only advances on clocks that retire, so the count holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_reg <= '0;
    end else if (retire) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_RTYPEWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_BEQEX: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_JEX: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  mainfsm_ctl u_ctl (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  always_comb begin
    memwrite = ctl.memwrite;
    iord     = ctl.iord;
    irwrite  = ctl.irwrite;
    regdst   = ctl.regdst;
    memtoreg = ctl.memtoreg;
    regwrite = ctl.regwrite;
    alusrca  = ctl.alusrca;
    branch   = ctl.branch;
    pcwrite  = ctl.pcwrite;
    alusrcb  = ctl.alusrcb;
    pcsrc    = ctl.pcsrc;
    aluop    = ctl.aluop;
    illegal  = (state_reg == S_DECODE) && !op_legal(op);
    state    = state_reg;
    instret  = instret_reg;
  end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: per-cycle expectations are queued as
// stimulus is driven and compared against the DUT outputs mid-cycle.
module tb_mainfsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        mem_ready;
  logic        memwrite, iord, irwrite, regdst, memtoreg, regwrite;
  logic        alusrca, branch, pcwrite, illegal;
  logic [1:0]  alusrcb, pcsrc, aluop;
  logic [3:0]  state;
  logic [31:0] instret;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .branch(branch), .pcwrite(pcwrite), .illegal(illegal),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed as {memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,branch,pcwrite,illegal,alusrcb,pcsrc,aluop}
  function automatic logic [15:0] ref_ctl(input logic [3:0] st, input logic mr, input logic [5:0] o);
    logic legal;
    legal = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
            (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    case (st)
      4'd0:  return {2'b00, mr, 5'b00000, mr, 1'b0, 2'b01, 2'b00, 2'b00};
      4'd1:  return {9'b0, !legal, 2'b11, 2'b00, 2'b00};
      4'd2:  return {6'b000000, 1'b1, 3'b000, 2'b10, 2'b00, 2'b00};
      4'd3:  return {1'b0, 1'b1, 8'b0, 6'b0};
      4'd4:  return {4'b0000, 1'b1, 1'b1, 4'b0000, 6'b0};
      4'd5:  return {1'b1, 1'b1, 8'b0, 6'b0};
      4'd6:  return {6'b000000, 1'b1, 3'b000, 2'b00, 2'b00, 2'b10};
      4'd7:  return {3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 6'b0};
      4'd8:  return {6'b000000, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01};
      4'd9:  return {6'b000000, 1'b1, 3'b000, 2'b10, 2'b00, 2'b00};
      4'd10: return {5'b00000, 1'b1, 4'b0000, 6'b0};
      4'd11: return {8'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00};
      default: return 16'h0000;
    endcase
  endfunction

  // Called just after a falling edge: drive, queue expectation, compare, move to next falling edge.
  task automatic step(input string tag, input logic [5:0] o, input logic mr,
                      input logic [3:0] est, input logic [31:0] eir);
    exp_t e;
    op        = o;
    mem_ready = mr;
    e.tag = tag;
    e.st  = est;
    e.ctl = ref_ctl(est, mr, o);
    e.ir  = eir;
    sbq.push_back(e);
    #2;
    e = sbq.pop_front();
    chk({e.tag, ".state"}, {28'd0, state}, {28'd0, e.st});
    chk({e.tag, ".ctl"}, {16'd0, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
        alusrca, branch, pcwrite, illegal, alusrcb, pcsrc, aluop}, {16'd0, e.ctl});
    chk({e.tag, ".instret"}, instret, e.ir);
    $display("%0t %s op=%b mr=%b state=%0d instret=%h", $time, e.tag, o, mr, state, instret);
    @(negedge clk);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, BAD = 6'b111111;

  initial begin
    reset = 1'b0;
    op = 6'h00;
    mem_ready = 1'b0;
    @(negedge clk);
    // held in reset: FETCH decode with mem_ready gating, no movement
    step("rst_mr0", BAD, 1'b0, 4'd0, 32'd0);
    step("rst_mr1", BAD, 1'b1, 4'd0, 32'd0);
    reset = 1'b1;

    // lw, no stalls
    step("lw.f",  BAD, 1'b1, 4'd0, 32'd0);
    step("lw.d",  LW,  1'b1, 4'd1, 32'd0);
    step("lw.ma", LW,  1'b1, 4'd2, 32'd0);
    step("lw.mr", BAD, 1'b1, 4'd3, 32'd0);
    step("lw.wb", BAD, 1'b1, 4'd4, 32'd0);

    // sw with fetch stall and three MEMWR wait cycles; op noise outside DECODE/MEMADR
    step("sw.f0", JJ,  1'b0, 4'd0, 32'd1);
    step("sw.f1", BAD, 1'b1, 4'd0, 32'd1);
    step("sw.d",  SW,  1'b1, 4'd1, 32'd1);
    step("sw.ma", SW,  1'b1, 4'd2, 32'd1);
    step("sw.w0", LW,  1'b0, 4'd5, 32'd1);
    step("sw.w1", RT,  1'b0, 4'd5, 32'd1);
    step("sw.w2", JJ,  1'b0, 4'd5, 32'd1);
    step("sw.w3", BAD, 1'b1, 4'd5, 32'd1);

    // R-type, beq, j back to back
    step("rt.f",  BAD, 1'b1, 4'd0, 32'd2);
    step("rt.d",  RT,  1'b1, 4'd1, 32'd2);
    step("rt.ex", JJ,  1'b1, 4'd6, 32'd2);
    step("rt.wb", SW,  1'b1, 4'd7, 32'd2);
    step("bq.f",  BAD, 1'b1, 4'd0, 32'd3);
    step("bq.d",  BQ,  1'b1, 4'd1, 32'd3);
    step("bq.ex", LW,  1'b1, 4'd8, 32'd3);
    step("j.f",   BAD, 1'b1, 4'd0, 32'd4);
    step("j.d",   JJ,  1'b1, 4'd1, 32'd4);
    step("j.ex",  RT,  1'b1, 4'd11, 32'd4);

    // illegal opcode: one DECODE cycle with illegal, back to FETCH, no retire
    step("il.f",  BAD, 1'b1, 4'd0, 32'd5);
    step("il.d",  BAD, 1'b1, 4'd1, 32'd5);
    step("il.f2", BAD, 1'b0, 4'd0, 32'd5);
    step("il.f3", BAD, 1'b1, 4'd0, 32'd5);

    // lw stalled in MEMRD, then asynchronous reset between edges
    step("ar.d",  LW,  1'b1, 4'd1, 32'd5);
    step("ar.ma", LW,  1'b1, 4'd2, 32'd5);
    step("ar.s0", BAD, 1'b0, 4'd3, 32'd5);
    op = BAD;
    mem_ready = 1'b0;
    #1;
    chk("ar.pre.state", {28'd0, state}, 32'd3);
    reset = 1'b0;
    #1;
    chk("ar.async.state", {28'd0, state}, 32'd0);
    chk("ar.async.instret", instret, 32'd0);
    chk("ar.async.irwrite", {31'd0, irwrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // preload count to all-ones, retire addi, count wraps
    force dut.instret_reg = 32'hFFFF_FFFF;
    step("ad.f",  BAD, 1'b1, 4'd0, 32'hFFFF_FFFF);
    release dut.instret_reg;
    step("ad.d",  AI,  1'b1, 4'd1, 32'hFFFF_FFFF);
    step("ad.ex", BAD, 1'b1, 4'd9, 32'hFFFF_FFFF);
    step("ad.wb", BAD, 1'b1, 4'd10, 32'hFFFF_FFFF);
    step("ad.f2", BAD, 1'b0, 4'd0, 32'd0);

    chk("sbq.empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
